md5_hex_emitter: RTL and testbench
==================================

// Module: md5_hex_emitter
// PURPOSE
//  Return path of the MD5 console. Accepts one finished 128-bit digest (words A,B,C,D)
//  and transmits it as 32 lowercase/uppercase ASCII hex characters, optionally followed
//  by CR (8'h0d), over a valid/ready character stream into the console character writer.
//  Bytes go out in standard MD5 order, so the console line reads e.g. "d41d8cd9...".
// PARAMETERS
//  UPPERCASE  0  1: hex letters 8'h41-8'h46 ("A"-"F"); 0: 8'h61-8'h66 ("a"-"f")
//  APPEND_CR  1  1: emit 8'h0d after the 32nd hex character; 0: no terminator
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  reset      in   1   asynchronous, active-low reset (0 = reset)
//  abort      in   1   synchronous cancel of the current digest
//  dig_valid  in   1   digest words present
//  dig_ready  out  1   block can capture a digest (IDLE only)
//  dig_a      in   32  MD5 word A
//  dig_b      in   32  MD5 word B
//  dig_c      in   32  MD5 word C
//  dig_d      in   32  MD5 word D
//  ch_valid   out  1   ch_data holds a character to write
//  ch_ready   in   1   writer accepts ch_data this cycle
//  ch_data    out  8   ASCII character
//  busy       out  1   state != IDLE
//  done       out  1   one-cycle pulse: full sequence accepted
// BEHAVIOUR
//  Reset values: dig_ready=1, ch_valid=0, ch_data=8'h00, busy=0, done=0, nib=0, state=IDLE.
//  States: IDLE -> EMIT -> (TERM if APPEND_CR) -> IDLE.
//  IDLE: dig_ready=1. On dig_valid=1 at an edge, latch {dig_a,dig_b,dig_c,dig_d} into a
//   128-bit holding register, set nib=0, state=EMIT, ch_valid=1, ch_data=char(nibble 0).
//   Latency capture->first ch_valid: 1 edge (visible the cycle after capture).
//  Nibble n (0..31) selection: word = n[4:3] (0=A,1=B,2=C,3=D); byte = n[2:1] (0 = bits
//   7:0, little-endian); n[0]=0 -> byte[7:4], n[0]=1 -> byte[3:0].
//  Hex map: 0-9 -> 8'h30+v; 10-15 -> (UPPERCASE ? 8'h41 : 8'h61)+v-10.
//  Handshake: transfer = ch_valid & ch_ready. While ch_valid=1 and ch_ready=0, ch_data and
//   ch_valid hold unchanged. ch_valid never drops without a transfer except via abort/reset.
//  EMIT: on transfer with nib<31: nib<=nib+1, ch_data<=char(nib+1); one char per cycle
//   with ch_ready held high. On transfer with nib==31: APPEND_CR=1 -> ch_data<=8'h0d,
//   state=TERM; APPEND_CR=0 -> ch_valid<=0, done<=1, state=IDLE.
//  TERM: on transfer: ch_valid<=0, done<=1, state=IDLE.
//  done is registered: high exactly the cycle after the final transfer; dig_ready=1 in that
//   same cycle, so a back-to-back digest may be captured on the edge ending the done cycle.
//  Digest inputs are ignored outside IDLE; holding register is immune to input changes.
//  abort=1 (any state): next edge ch_valid=0, state=IDLE, nib=0, done stays 0; a transfer
//   coinciding with abort is counted by the writer but the sequence is not completed.
//   abort in IDLE has priority over capture (dig_valid ignored that edge).
//  reset mid-sequence: immediate return to reset values, no done pulse.
//  Totals, ch_ready=1 continuously: APPEND_CR=1 -> 33 transfers, done 34 cycles after the
//   capture edge; APPEND_CR=0 -> 32 transfers, done 33 cycles after the capture edge.
// TESTING
//  1 MD5(""): A=d98c1dd4 B=04b2008f C=980980e9 D=7e42f8ec, ch_ready=1 -> ch_data stream
//    "d41d8cd98f00b204e9800998ecf8427e" then 8'h0d; done 1 cycle after CR; 33 transfers.
//  2 MD5("abc") with ch_ready toggled random/held low 5 cycles -> "900150983cd24fb0d6963f7d
//    28e17f72"+CR; ch_data stable whenever ch_valid & !ch_ready; no char dropped/duplicated.
//  3 UPPERCASE=1, APPEND_CR=0, A=B=C=D=32'hffffffff -> 32x 8'h46, no 8'h0d, done after 32nd.
//  4 dig_valid held high, digests X then Y -> X fully emitted, Y captured only in done cycle;
//    dig_* changes during EMIT have no effect on output.
//  5 abort after 10 transfers -> ch_valid=0 next cycle, no done, dig_ready=1; new digest
//    emits from nibble 0.
//  6 reset asserted at nibble 20 while ch_valid=1 -> outputs at reset values asynchronously;
//    after release, clean full sequence for next digest.

Source files
------------

// File: rtl/md5_hex_emitter.sv
// md5_hex_emitter: streams a captured 128-bit MD5 digest as 32 ASCII hex characters, optionally CR-terminated
module md5_hex_emitter #(
    parameter bit UPPERCASE = 1'b0,
    parameter bit APPEND_CR = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        abort,
    input  logic        dig_valid,
    output logic        dig_ready,
    input  logic [31:0] dig_a,
    input  logic [31:0] dig_b,
    input  logic [31:0] dig_c,
    input  logic [31:0] dig_d,
    output logic        ch_valid,
    input  logic        ch_ready,
    output logic [7:0]  ch_data,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, EMIT, TERM} state_t;
    state_t       state, state_n;
    logic [4:0]   nib, nib_n;
    logic [127:0] hold, hold_n, din;
    logic         valid_n, done_n, xfer;
    logic [7:0]   data_n;
    // word A sits in the top bits; bytes within a word go out little-endian, high nibble first
    function automatic logic [7:0] hex_char(input logic [127:0] d, input logic [4:0] n);
        logic [31:0] w;
        logic [7:0]  b;
        logic [3:0]  v;
        w = d[{~n[4:3], 5'd0} +: 32];
        b = w[{n[2:1], 3'd0} +: 8];
        v = n[0] ? b[3:0] : b[7:4];
        return (v < 4'd10) ? 8'h30 + {4'd0, v} : (UPPERCASE ? 8'h37 : 8'h57) + {4'd0, v};
    endfunction
    assign din       = {dig_a, dig_b, dig_c, dig_d};
    assign xfer      = ch_valid & ch_ready;
    assign dig_ready = state == IDLE;
    assign busy      = state != IDLE;
    always_comb begin
        state_n = state;
        nib_n   = nib;
        hold_n  = hold;
        valid_n = ch_valid;
        data_n  = ch_data;
        done_n  = 1'b0;
        if (abort) begin
            state_n = IDLE;
            nib_n   = 5'd0;
            valid_n = 1'b0;
        end else begin
            case (state)
                IDLE: if (dig_valid) begin
                    hold_n  = din;
                    nib_n   = 5'd0;
                    state_n = EMIT;
                    valid_n = 1'b1;
                    data_n  = hex_char(din, 5'd0);
                end
                EMIT: if (xfer) begin
                    if (nib != 5'd31) begin
                        nib_n  = nib + 5'd1;
                        data_n = hex_char(hold, nib + 5'd1);
                    end else if (APPEND_CR) begin
                        data_n  = 8'h0d;
                        state_n = TERM;
                    end else begin
                        valid_n = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
                TERM: if (xfer) begin
                    valid_n = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            nib      <= 5'd0;
            hold     <= '0;
            ch_valid <= 1'b0;
            ch_data  <= 8'h00;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            nib      <= nib_n;
            hold     <= hold_n;
            ch_valid <= valid_n;
            ch_data  <= data_n;
            done     <= done_n;
        end
    end
endmodule

// File: tb/tb_md5_hex_emitter.sv
// tb_md5_hex_emitter: directed checks of the hex emitter, default and uppercase/no-CR builds
module tb_md5_hex_emitter;
    logic        clk = 1'b0, reset = 1'b0, abort = 1'b0, ch_ready = 1'b0;
    logic        dig_valid = 1'b0, dig_valid2 = 1'b0;
    logic [31:0] dig_a = '0, dig_b = '0, dig_c = '0, dig_d = '0;
    logic        dr1, cv1, busy1, dn1, dr2, cv2, busy2, dn2;
    logic [7:0]  cd1, cd2;
    logic        sel = 1'b0;
    logic        dr, cv, busy, dn;
    logic [7:0]  cd;
    int          n_chk = 0, n_fail = 0;
    string       sx = "d41d8cd98f00b204e9800998ecf8427e";
    string       sy = "900150983cd24fb0d6963f7d28e17f72";
    string       sf = "FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF";

    always #5 clk = ~clk;

    md5_hex_emitter u1 (
        .clk(clk), .reset(reset), .abort(abort), .dig_valid(dig_valid), .dig_ready(dr1),
        .dig_a(dig_a), .dig_b(dig_b), .dig_c(dig_c), .dig_d(dig_d),
        .ch_valid(cv1), .ch_ready(ch_ready), .ch_data(cd1), .busy(busy1), .done(dn1)
    );
    md5_hex_emitter #(.UPPERCASE(1'b1), .APPEND_CR(1'b0)) u2 (
        .clk(clk), .reset(reset), .abort(abort), .dig_valid(dig_valid2), .dig_ready(dr2),
        .dig_a(dig_a), .dig_b(dig_b), .dig_c(dig_c), .dig_d(dig_d),
        .ch_valid(cv2), .ch_ready(ch_ready), .ch_data(cd2), .busy(busy2), .done(dn2)
    );

    assign dr   = sel ? dr2 : dr1;
    assign cv   = sel ? cv2 : cv1;
    assign cd   = sel ? cd2 : cd1;
    assign busy = sel ? busy2 : busy1;
    assign dn   = sel ? dn2 : dn1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic set_dig(input logic [31:0] a, b, c, d);
        dig_a = a; dig_b = b; dig_c = c; dig_d = d;
    endtask

    task automatic capture(input logic [31:0] a, b, c, d, input bit second);
        set_dig(a, b, c, d);
        if (second) dig_valid2 = 1'b1; else dig_valid = 1'b1;
        @(negedge clk);
        dig_valid = 1'b0;
        dig_valid2 = 1'b0;
    endtask

    // consumes the whole character stream of the selected DUT, then checks the done cycle
    task automatic emit(input string s, input bit cr, input bit rnd, input string tag);
        int total = s.len() + (cr ? 1 : 0);
        int idx = 0;
        int cyc = 0;
        bit stall = 1'b0;
        logic [7:0] prev = 8'h00;
        logic [7:0] expc;
        while (idx < total && cyc < 400) begin
            ch_ready = rnd ? (cyc >= 5 && $urandom_range(0, 2) != 0) : 1'b1;
            check({tag, " valid"}, 32'(cv), 32'd1);
            if (stall) check({tag, " stable"}, 32'(cd), 32'(prev));
            if (cv && ch_ready) begin
                expc = (idx < s.len()) ? s[idx] : 8'h0d;
                check($sformatf("%s char%0d", tag, idx), 32'(cd), 32'(expc));
                idx++;
            end
            stall = cv && !ch_ready;
            prev = cd;
            @(negedge clk);
            cyc++;
        end
        check({tag, " transfers"}, 32'(idx), 32'(total));
        if (!rnd) check({tag, " cycles"}, 32'(cyc), 32'(total));
        check({tag, " done"}, 32'(dn), 32'd1);
        check({tag, " valid_off"}, 32'(cv), 32'd0);
        check({tag, " ready_in_done"}, 32'(dr), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst dig_ready", 32'(dr), 32'd1);
        check("rst ch_valid", 32'(cv), 32'd0);
        check("rst ch_data", 32'(cd), 32'h00);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(dn), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        // MD5("") with ch_ready held high
        capture(32'hd98c1dd4, 32'h04b2008f, 32'h980980e9, 32'h7e42f8ec, 1'b0);
        check("t1 first valid", 32'(cv), 32'd1);
        check("t1 first char", 32'(cd), 32'h64);
        check("t1 busy", 32'(busy), 32'd1);
        check("t1 not ready", 32'(dr), 32'd0);
        emit(sx, 1'b1, 1'b0, "t1");
        @(negedge clk);
        check("t1 done pulse", 32'(dn), 32'd0);
        // MD5("abc") with back-pressure
        capture(32'h98500190, 32'hb04fd23c, 32'h7d3f96d6, 32'h727fe128, 1'b0);
        emit(sy, 1'b1, 1'b1, "t2");
        // uppercase, no terminator
        sel = 1'b1;
        capture(32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff, 1'b1);
        emit(sf, 1'b0, 1'b0, "t3");
        sel = 1'b0;
        @(negedge clk);
        // dig_valid held high, digest changed during EMIT
        set_dig(32'hd98c1dd4, 32'h04b2008f, 32'h980980e9, 32'h7e42f8ec);
        dig_valid = 1'b1;
        @(negedge clk);
        set_dig(32'h98500190, 32'hb04fd23c, 32'h7d3f96d6, 32'h727fe128);
        emit(sx, 1'b1, 1'b0, "t4x");
        @(negedge clk);
        dig_valid = 1'b0;
        check("t4 y captured", 32'(cv), 32'd1);
        check("t4 y first", 32'(cd), 32'h39);
        emit(sy, 1'b1, 1'b0, "t4y");
        // abort after 10 transfers
        capture(32'h98500190, 32'hb04fd23c, 32'h7d3f96d6, 32'h727fe128, 1'b0);
        ch_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("t5 nib10", 32'(cd), 32'(sy[10]));
        abort = 1'b1;
        ch_ready = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        check("t5 valid off", 32'(cv), 32'd0);
        check("t5 ready", 32'(dr), 32'd1);
        check("t5 no done", 32'(dn), 32'd0);
        @(negedge clk);
        check("t5 no done later", 32'(dn), 32'd0);
        capture(32'hd98c1dd4, 32'h04b2008f, 32'h980980e9, 32'h7e42f8ec, 1'b0);
        emit(sx, 1'b1, 1'b0, "t5");
        // asynchronous reset mid-stream
        capture(32'h98500190, 32'hb04fd23c, 32'h7d3f96d6, 32'h727fe128, 1'b0);
        ch_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("t6 nib20", 32'(cd), 32'(sy[20]));
        #2 reset = 1'b0;
        #1;
        check("t6 rst valid", 32'(cv), 32'd0);
        check("t6 rst data", 32'(cd), 32'h00);
        check("t6 rst ready", 32'(dr), 32'd1);
        check("t6 rst busy", 32'(busy), 32'd0);
        check("t6 rst done", 32'(dn), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6 no done", 32'(dn), 32'd0);
        capture(32'hd98c1dd4, 32'h04b2008f, 32'h980980e9, 32'h7e42f8ec, 1'b0);
        emit(sx, 1'b1, 1'b0, "t6");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
